// File: rtl/first_nios2_system_cpu_mul_sched.sv
// first_nios2_system_cpu_mul_sched: round-robin scheduler sharing one
// registered 16x16 unsigned multiplier between two requesters; builds a
// 64-bit product from four partial products.
// Optional feature: define MUL_SCHED_SIGNED_EN for signed high-word fix-up.
module first_nios2_system_cpu_mul_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_signed,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_lo,
  output logic [31:0] resp_hi,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
`ifdef MUL_SCHED_SIGNED_EN
    S_FIX,
`endif
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        id_q, id_d;
  logic        last_grant_q, last_grant_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] prod_q, prod_d;
`ifdef MUL_SCHED_SIGNED_EN
  logic        sgn_q, sgn_d;
`else
  logic        unused_signed;
  assign unused_signed = req0_signed ^ req1_signed;
`endif

  logic        grant0, grant1;
  logic [15:0] op_a, op_b;
  logic [5:0]  shamt;
  logic [63:0] addend;

  // Arbitration, operand selection and accumulator addend.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant_q);
    grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    op_a   = k_q[0] ? a_q[31:16] : a_q[15:0];
    op_b   = k_q[1] ? b_q[31:16] : b_q[15:0];
    // prod_q holds the partial from the previous index, so its weight follows k-1
    if (state_q == S_DRAIN)  shamt = 6'd32;
    else if (k_q == 2'd1)    shamt = 6'd0;
    else                     shamt = 6'd16;
    addend = {32'd0, prod_q} << shamt;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    acc_d        = acc_q;
    prod_d       = prod_q;
`ifdef MUL_SCHED_SIGNED_EN
    sgn_d        = sgn_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant0 | grant1) begin
          a_d          = grant1 ? req1_a : req0_a;
          b_d          = grant1 ? req1_b : req0_b;
`ifdef MUL_SCHED_SIGNED_EN
          sgn_d        = grant1 ? req1_signed : req0_signed;
`endif
          id_d         = grant1;
          last_grant_d = grant1;
          acc_d        = '0;
          k_d          = 2'd0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        prod_d = {16'd0, op_a} * {16'd0, op_b};
        if (k_q != 2'd0) acc_d = acc_q + addend;
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        acc_d = acc_q + addend;
`ifdef MUL_SCHED_SIGNED_EN
        state_d = S_FIX;
`else
        state_d = S_RESP;
`endif
      end
`ifdef MUL_SCHED_SIGNED_EN
      S_FIX: begin
        if (sgn_q)
          acc_d[63:32] = acc_q[63:32] - (a_q[31] ? b_q : 32'd0) - (b_q[31] ? a_q : 32'd0);
        state_d = S_RESP;
      end
`endif
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      acc_q        <= '0;
      prod_q       <= '0;
`ifdef MUL_SCHED_SIGNED_EN
      sgn_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      acc_q        <= acc_d;
      prod_q       <= prod_d;
`ifdef MUL_SCHED_SIGNED_EN
      sgn_q        <= sgn_d;
`endif
    end
  end

  // Handshake and result outputs.
  always_comb begin
    req0_ready = (state_q == S_IDLE) & grant0 & ~reset;
    req1_ready = (state_q == S_IDLE) & grant1 & ~reset;
    resp_valid = (state_q == S_RESP);
    busy       = (state_q != S_IDLE);
    resp_id    = id_q;
    resp_lo    = acc_q[31:0];
    resp_hi    = acc_q[63:32];
  end

endmodule
